hex_entry_driver: RTL and testbench

HEX_ENTRY_DRIVER -- requirements
Module: hex_entry_driver

---
 rtl/hex_entry_driver_pkg.sv | 35 +++
 rtl/hex_entry_driver_btn_debounce.sv | 53 +++++
 rtl/hex_entry_driver.sv | 147 ++++++++++++++
 tb/tb_hex_entry_driver.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_driver_pkg.sv
// Shared constants for the hex entry driver.
// Button indices, segment table and blank code.
package hex_entry_driver_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_SET   = 2;
    localparam int BTN_SEL   = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_entry_driver_btn_debounce.sv
// Button synchroniser plus debouncer.
// Emits a one-cycle press on an accepted release-to-press change.
import hex_entry_driver_pkg::*;

module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // Two-flop synchroniser, idles released
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level after DEB_CYCLES equal differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2;
                cnt_q   <= '0;
                press   <= level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_entry_driver.sv
// Hex entry front panel: cursor, edit registers,
// commit handshake and blinking 7-segment window.
import hex_entry_driver_pkg::*;

module hex_entry_driver #(
    parameter int NIBBLES    = 32,
    parameter int NREG       = 2,
    parameter int DIGITS     = 8,
    parameter int DEB_CYCLES = 16,
    parameter int BLINK_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [3:0]                           btn,
    input  logic                                 commit_mode,
    input  logic [3:0]                           data_sw,
    output logic [DIGITS*7-1:0]                  seg7,
    output logic [$clog2(NIBBLES)-1:0]           pos_led,
    output logic [((NREG>1)?$clog2(NREG):1)-1:0] reg_sel,
    output logic [NREG*NIBBLES*4-1:0]            out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy_led
);

    localparam int PW    = $clog2(NIBBLES);
    localparam int RW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int RBITS = NIBBLES * 4;

    logic [3:0]                       press;
    logic [NREG-1:0][RBITS-1:0]       edit_q;
    logic [PW-1:0]                    pos_q;
    logic [RW-1:0]                    sel_q;
    logic [BLINK_BITS-1:0]            blink_q;
    logic                             valid_q;
    logic [NREG*RBITS-1:0]            data_q;
    logic [DIGITS*7-1:0]              seg_q;
    logic [DIGITS*7-1:0]              seg_d;
    logic [RBITS-1:0]                 cur_reg;
    logic                             go_left;
    logic                             go_right;
    logic                             sel_go;
    logic                             commit_go;
    int                               win_base;

    for (genvar b = 0; b < 4; b++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn[b]),
            .press  (press[b])
        );
    end

    assign go_left   = press[BTN_LEFT] & ~press[BTN_RIGHT]
                     & ~press[BTN_SET];
    assign go_right  = press[BTN_RIGHT] & ~press[BTN_LEFT]
                     & ~press[BTN_SET];
    assign sel_go    = press[BTN_SEL] & ~commit_mode;
    assign commit_go = press[BTN_SEL] & commit_mode & ~valid_q;
    assign cur_reg   = edit_q[sel_q];

    // Cursor movement and register selection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q <= '0;
            sel_q <= '0;
        end else if (sel_go) begin
            pos_q <= '0;
            sel_q <= (sel_q == RW'(NREG - 1)) ? '0 : sel_q + 1'b1;
        end else if (go_left) begin
            pos_q <= (pos_q == PW'(NIBBLES - 1)) ? '0 : pos_q + 1'b1;
        end else if (go_right) begin
            pos_q <= (pos_q == '0) ? PW'(NIBBLES - 1) : pos_q - 1'b1;
        end
    end

    // Nibble write into the selected edit register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edit_q <= '0;
        end else if (press[BTN_SET]) begin
            edit_q[sel_q][{pos_q, 2'b00} +: 4] <= data_sw;
        end
    end

    // Commit snapshot and valid/ready handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (commit_go) begin
            valid_q <= 1'b1;
            data_q  <= edit_q;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Free-running blink phase counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + 1'b1;
        end
    end

    // Next display contents for the window around the cursor
    always_comb begin
        seg_d    = '0;
        win_base = (int'(pos_q) / DIGITS) * DIGITS;
        for (int i = 0; i < DIGITS; i++) begin
            if (win_base + i >= NIBBLES) begin
                seg_d[7*i +: 7] = SEG_BLANK;
            end else if ((win_base + i == int'(pos_q)) &&
                         blink_q[BLINK_BITS-1]) begin
                seg_d[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_d[7*i +: 7] =
                    hex_to_seg(cur_reg[4*(win_base+i) +: 4]);
            end
        end
    end

    // Registered segment outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                seg_q[7*i +: 7] <= (i >= NIBBLES) ? SEG_BLANK
                                                  : hex_to_seg(4'h0);
            end
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg7      = seg_q;
    assign pos_led   = pos_q;
    assign reg_sel   = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy_led  = valid_q & ~out_ready;

endmodule

// File: tb/tb_hex_entry_driver.sv
// Bench for hex_entry_driver: behavioural model compared
// every cycle, plus directed literal expectations.
module tb_hex_entry_driver;

    localparam int NIB  = 32;
    localparam int NREG = 2;
    localparam int DIG  = 8;
    localparam int DEB  = 16;
    localparam int BB   = 4;
    localparam int HOLD = 22;

    localparam int BL = 0;
    localparam int BR = 1;
    localparam int BS = 2;
    localparam int BC = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [3:0]             btn;
    logic                   commit_mode;
    logic [3:0]             data_sw;
    logic [DIG*7-1:0]       seg7;
    logic [4:0]             pos_led;
    logic [0:0]             reg_sel;
    logic [NREG*NIB*4-1:0]  out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy_led;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int bcnt   = 0;

    bit [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                              7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03,
                              7'h46, 7'h21, 7'h06, 7'h0E};

    // model state
    int               m_pos;
    int               m_sel;
    bit [3:0]         m_reg [NREG][NIB];
    bit [3:0]         m_od  [NREG][NIB];
    bit               m_ov;
    int               m_cyc;
    int               m_edge = 0;
    bit [63:0]        m_hist [4];
    bit               m_lvl  [4];
    bit               m_pend [4];
    int               m_npress [4];
    int               m_press_at [4];
    logic [DIG*7-1:0] m_seg;

    hex_entry_driver #(
        .NIBBLES   (NIB),
        .NREG      (NREG),
        .DIGITS    (DIG),
        .DEB_CYCLES(DEB),
        .BLINK_BITS(BB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .commit_mode(commit_mode),
        .data_sw    (data_sw),
        .seg7       (seg7),
        .pos_led    (pos_led),
        .reg_sel    (reg_sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy_led   (busy_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_pos = 0;
        m_sel = 0;
        m_ov  = 1'b0;
        m_cyc = 0;
        for (int r = 0; r < NREG; r++)
            for (int n = 0; n < NIB; n++) begin
                m_reg[r][n] = 4'h0;
                m_od[r][n]  = 4'h0;
            end
        for (int b = 0; b < 4; b++) begin
            m_hist[b] = '1;
            m_lvl[b]  = 1'b1;
            m_pend[b] = 1'b0;
        end
        for (int i = 0; i < DIG; i++)
            m_seg[7*i +: 7] = (i >= NIB) ? 7'h7F : 7'h40;
    endtask

    task automatic m_step();
        int        base;
        bit        blink;
        bit        l, r, s, c;
        bit [63:0] w;
        bit [63:0] mask;
        m_edge++;
        blink = (m_cyc % (1 << BB)) >= (1 << (BB - 1));
        base  = (m_pos / DIG) * DIG;
        for (int i = 0; i < DIG; i++) begin
            if (base + i >= NIB)
                m_seg[7*i +: 7] = 7'h7F;
            else if (base + i == m_pos && blink)
                m_seg[7*i +: 7] = 7'h7F;
            else
                m_seg[7*i +: 7] = SEGTAB[m_reg[m_sel][base+i]];
        end
        l = m_pend[BL];
        r = m_pend[BR];
        s = m_pend[BS];
        c = m_pend[BC];
        if (c && commit_mode && !m_ov) begin
            m_od = m_reg;
            m_ov = 1'b1;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        if (s)
            m_reg[m_sel][m_pos] = data_sw;
        else if (l && !r)
            m_pos = (m_pos + 1) % NIB;
        else if (r && !l)
            m_pos = (m_pos + NIB - 1) % NIB;
        if (c && !commit_mode) begin
            m_sel = (m_sel + 1) % NREG;
            m_pos = 0;
        end
        m_cyc++;
        mask = (64'd1 << DEB) - 64'd1;
        for (int b = 0; b < 4; b++) begin
            m_hist[b] = {m_hist[b][62:0], btn[b]};
            w = (m_hist[b] >> 2) & mask;
            m_pend[b] = 1'b0;
            if (m_lvl[b] && w == 64'd0) begin
                m_lvl[b]  = 1'b0;
                m_pend[b] = 1'b1;
                m_npress[b]++;
                m_press_at[b] = m_edge;
            end else if (!m_lvl[b] && w == mask) begin
                m_lvl[b] = 1'b1;
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 4; b++) begin
            m_npress[b]   = 0;
            m_press_at[b] = 0;
        end
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_reset();
            else m_step();
        end
    end

    // per-cycle comparison against the model
    initial begin
        logic [NREG*NIB*4-1:0] exp_od;
        forever begin
            @(negedge clk);
            #1;
            for (int r = 0; r < NREG; r++)
                for (int n = 0; n < NIB; n++)
                    exp_od[(r*NIB+n)*4 +: 4] = m_od[r][n];
            chk("seg7", seg7, m_seg);
            chk("pos_led", pos_led, m_pos);
            chk("reg_sel", reg_sel, m_sel);
            chk("out_data", out_data, exp_od);
            chk("out_valid", out_valid, m_ov);
            chk("busy_led", busy_led, m_ov && !out_ready);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1) vcnt++;
            if (busy_led === 1'b1) bcnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t limit reached", $time);
        $fatal(1, "watchdog");
    end

    task automatic press(input int b);
        @(negedge clk);
        btn[b] = 1'b0;
        repeat (HOLD) @(negedge clk);
        btn[b] = 1'b1;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic press2(input int a, input int b);
        @(negedge clk);
        btn[a] = 1'b0;
        btn[b] = 1'b0;
        repeat (HOLD) @(negedge clk);
        btn[a] = 1'b1;
        btn[b] = 1'b1;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic wait_digit(input int d, input logic [6:0] v,
                              input string nm);
        int n = 0;
        while (seg7[7*d +: 7] !== v && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, seg7[7*d +: 7], v);
    endtask

    initial begin
        int last_edge;
        int n0;
        int n;
        btn         = 4'hF;
        commit_mode = 1'b0;
        data_sw     = 4'h0;
        out_ready   = 1'b0;
        reset       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("lit_reset_seg7", seg7, {DIG{7'h40}});
        chk("lit_reset_pos", pos_led, 0);
        chk("lit_reset_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b1;

        press(BR);
        chk("lit_wrap_right", pos_led, 31);
        press(BL);
        chk("lit_wrap_left", pos_led, 0);

        repeat (9) press(BL);
        chk("lit_pos9", pos_led, 9);
        data_sw = 4'hA;
        press(BS);
        wait_digit(1, 7'h08, "lit_edit_digit1");
        chk("lit_edit_digit0", seg7[6:0], 7'h40);
        chk("lit_edit_digit2", seg7[20:14], 7'h40);

        data_sw = 4'h3;
        press2(BS, BL);
        chk("lit_prio_pos", pos_led, 9);
        wait_digit(1, 7'h30, "lit_prio_digit1");

        data_sw = 4'h5;
        n0 = m_npress[BS];
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            btn[BS] = ~btn[BS];
            repeat (3) @(negedge clk);
        end
        btn[BS]   = 1'b0;
        last_edge = m_edge;
        repeat (25) @(negedge clk);
        btn[BS] = 1'b1;
        repeat (25) @(negedge clk);
        chk("lit_bounce_count", m_npress[BS] - n0, 1);
        chk("lit_bounce_delay", m_press_at[BS] - last_edge, 18);
        wait_digit(1, 7'h12, "lit_bounce_digit1");

        press(BC);
        chk("lit_sel_reg", reg_sel, 1);
        chk("lit_sel_pos", pos_led, 0);
        data_sw = 4'hC;
        press(BS);

        commit_mode = 1'b1;
        vcnt = 0;
        bcnt = 0;
        @(negedge clk);
        btn[BC] = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("lit_commit_rise", out_valid, 1);
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        btn[BC]   = 1'b1;
        repeat (25) @(negedge clk);
        chk("lit_valid_cycles", vcnt, 11);
        chk("lit_busy_cycles", bcnt, 10);
        chk("lit_commit_data", out_data,
            {128'h0000_0000_0000_0000_0000_0000_0000_000C,
             128'h0000_0000_0000_0000_0000_0050_0000_0000});
        chk("lit_valid_clear", out_valid, 0);

        out_ready = 1'b0;
        press(BC);
        chk("lit_commit2_valid", out_valid, 1);
        data_sw = 4'h7;
        press(BS);
        press(BC);
        chk("lit_drop_data", out_data,
            {128'h0000_0000_0000_0000_0000_0000_0000_000C,
             128'h0000_0000_0000_0000_0000_0050_0000_0000});
        chk("lit_drop_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("lit_drop_clear", out_valid, 0);
        out_ready = 1'b0;
        repeat (30) @(negedge clk);
        chk("lit_no_queue", out_valid, 0);

        press(BL);
        chk("lit_pos1", pos_led, 1);
        press(BC);
        chk("lit_commit3_valid", out_valid, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("lit_rst_valid", out_valid, 0);
        chk("lit_rst_pos", pos_led, 0);
        chk("lit_rst_data", out_data, 0);
        chk("lit_rst_sel", reg_sel, 0);
        chk("lit_rst_seg7", seg7, {DIG{7'h40}});
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
